// File: rtl/bit_set_arbiter_pkg.sv
// Shared definitions for the bit_set_arbiter block: FSM state encoding and default sizing.
package bit_set_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_HOLD_CYCLES = 2;

endpackage

// File: rtl/bit_set_arbiter_if.sv
// Requester-side and stage-side signal bundle of bit_set_arbiter.
interface bit_set_arbiter_if #(
  parameter int NUM_REQ = bit_set_arbiter_pkg::DEF_NUM_REQ
);
  logic [NUM_REQ-1:0]   reqIn;
  logic [2*NUM_REQ-1:0] dataIn;
  logic [NUM_REQ-1:0]   grantOut;
  logic [NUM_REQ-1:0]   doneOut;
  logic                 bitEnable;
  logic                 bitIn1;
  logic                 bitIn2;
  logic                 busy;

  modport master (
    output reqIn, dataIn,
    input  grantOut, doneOut, bitEnable, bitIn1, bitIn2, busy
  );

  modport slave (
    input  reqIn, dataIn,
    output grantOut, doneOut, bitEnable, bitIn1, bitIn2, busy
  );
endinterface

// File: rtl/bit_set_arbiter_rr_select.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo NUM_REQ.
module bit_set_arbiter_rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   sel,
  output logic               valid
);
  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   idx [NUM_REQ];

  // rot[k] is the request sitting k positions after the pointer
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [IDX_W:0] sum;
    assign sum     = {1'b0, ptr} + (IDX_W+1)'(gi);
    assign idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                                  : IDX_W'(sum);
    assign rot[gi] = req[idx[gi]];
  end

  always_comb begin
    sel   = '0;
    valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sel   = idx[k];
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bit_set_arbiter.sv
// Round-robin arbiter feeding one shared enable-gated bit-pair stage.
// Define BITSET_ARB_FIXED_PRIO_EN to pin the pointer at 0 (fixed lowest-index priority).
module bit_set_arbiter
  import bit_set_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic            clk,
  input  logic            reset,
  bit_set_arbiter_if.slave bus
);
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  if (HOLD_CYCLES < 1 || NUM_REQ < 2 || NUM_REQ > 8) begin : g_param_check
    $error("bit_set_arbiter: HOLD_CYCLES must be >= 1 and NUM_REQ in 2..8");
  end

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]   sel_reg, sel_next;
  logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic               bit_en_reg, bit_en_next;
  logic               bit1_reg, bit1_next;
  logic               bit2_reg, bit2_next;
  logic               busy_reg;

  logic [IDX_W-1:0]   pick;
  logic               pick_valid;

  bit_set_arbiter_rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req   (bus.reqIn),
    .ptr   (rr_ptr_reg),
    .sel   (pick),
    .valid (pick_valid)
  );

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    sel_next      = sel_reg;
    hold_cnt_next = hold_cnt_reg;
    grant_next    = grant_reg;
    done_next     = '0;
    bit_en_next   = bit_en_reg;
    bit1_next     = bit1_reg;
    bit2_next     = bit2_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          sel_next         = pick;
          grant_next       = '0;
          grant_next[pick] = 1'b1;
          bit1_next        = bus.dataIn[{pick, 1'b1}];
          bit2_next        = bus.dataIn[{pick, 1'b0}];
          bit_en_next      = 1'b1;
          hold_cnt_next    = CNT_W'(HOLD_CYCLES - 1);
          state_next       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_reg != '0) begin
          hold_cnt_next = hold_cnt_reg - 1'b1;
        end else begin
          bit_en_next        = 1'b0;
          grant_next         = '0;
          bit1_next          = 1'b0;
          bit2_next          = 1'b0;
          done_next[sel_reg] = 1'b1;
`ifdef BITSET_ARB_FIXED_PRIO_EN
          rr_ptr_next        = '0;
`else
          rr_ptr_next        = (sel_reg == IDX_W'(NUM_REQ - 1)) ? '0 : sel_reg + 1'b1;
`endif
          state_next         = ST_RELEASE;
        end
      end
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      rr_ptr_reg   <= '0;
      sel_reg      <= '0;
      hold_cnt_reg <= '0;
      grant_reg    <= '0;
      done_reg     <= '0;
      bit_en_reg   <= 1'b0;
      bit1_reg     <= 1'b0;
      bit2_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      sel_reg      <= sel_next;
      hold_cnt_reg <= hold_cnt_next;
      grant_reg    <= grant_next;
      done_reg     <= done_next;
      bit_en_reg   <= bit_en_next;
      bit1_reg     <= bit1_next;
      bit2_reg     <= bit2_next;
      busy_reg     <= (state_next != ST_IDLE);
    end
  end

  assign bus.grantOut  = grant_reg;
  assign bus.doneOut   = done_reg;
  assign bus.bitEnable = bit_en_reg;
  assign bus.bitIn1    = bit1_reg;
  assign bus.bitIn2    = bit2_reg;
  assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_bit_set_arbiter.sv
// Self-checking bench for bit_set_arbiter against a transaction-schedule reference model.
module tb_bit_set_arbiter;
  localparam int N = 4;
  localparam int H = 2;

  logic clk = 1'b0;
  logic reset;

  bit_set_arbiter_if #(.NUM_REQ(N)) bus ();

  bit_set_arbiter #(
    .NUM_REQ     (N),
    .HOLD_CYCLES (H)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model: a grant is a fixed schedule of H+2 cycles after the arbitration edge
  int         m_phase = -1;
  int         m_ptr   = 0;
  int         m_sel   = 0;
  logic [1:0] m_word;

  logic [N-1:0] e_grant, e_done;
  logic         e_en, e_b1, e_b2, e_busy;

  logic [N-1:0] prev_grant = '0;
  int           onset_cyc[$];
  logic [N-1:0] onset_val[$];
  logic [N-1:0] grant_or;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit found;
    e_grant = '0; e_done = '0; e_en = 0; e_b1 = 0; e_b2 = 0; e_busy = 0;
    if (reset) begin
      m_phase = -1;
      m_ptr   = 0;
      return;
    end
    if (m_phase < 0) begin
      if (bus.reqIn != '0) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (!found && bus.reqIn[i]) begin
            m_sel = i;
            found = 1;
          end
        end
        m_word  = bus.dataIn[2*m_sel +: 2];
        m_phase = 0;
      end
    end else begin
      m_phase++;
    end
    if (m_phase >= 0 && m_phase < H) begin
      e_grant[m_sel] = 1'b1;
      e_en           = 1'b1;
      {e_b1, e_b2}   = m_word;
      e_busy         = 1'b1;
    end else if (m_phase == H) begin
      e_done[m_sel] = 1'b1;
      e_busy        = 1'b1;
`ifndef BITSET_ARB_FIXED_PRIO_EN
      m_ptr = (m_sel + 1) % N;
`endif
    end else if (m_phase == H + 1) begin
      m_phase = -1;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check("grantOut",  32'(bus.grantOut),  32'(e_grant));
    check("doneOut",   32'(bus.doneOut),   32'(e_done));
    check("bitEnable", 32'(bus.bitEnable), 32'(e_en));
    check("bitIn1",    32'(bus.bitIn1),    32'(e_b1));
    check("bitIn2",    32'(bus.bitIn2),    32'(e_b2));
    check("busy",      32'(bus.busy),      32'(e_busy));
    if (prev_grant == '0 && bus.grantOut != '0) begin
      onset_cyc.push_back(cyc);
      onset_val.push_back(bus.grantOut);
    end
    prev_grant = bus.grantOut;
    grant_or   = grant_or | bus.grantOut;
  endtask

  task automatic drain();
    bus.reqIn = '0;
    for (int i = 0; i < 2 * (H + 2) && m_phase >= 0; i++) step();
    check("drain_idle", 32'(m_phase < 0), 32'd1);
  endtask

  initial begin
    logic [N-1:0] rr_exp [5];
    logic [N-1:0] fixed_exp;
`ifdef BITSET_ARB_FIXED_PRIO_EN
    rr_exp    = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    fixed_exp = 4'b0010;
`else
    rr_exp    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    fixed_exp = 4'b1010;
`endif
    grant_or   = '0;
    reset      = 1'b1;
    bus.reqIn  = 4'b1111;
    bus.dataIn = 8'h5A;

    // reset held two cycles with every requester active
    step();
    step();
    reset = 1'b0;
    onset_cyc.delete();
    onset_val.delete();

    // round-robin with all requests held; first grant follows reset release
    for (int i = 0; i < 5 * (H + 2); i++) step();
    check("rr_onsets", 32'(onset_val.size()), 32'd5);
    for (int i = 0; i < 5 && i < onset_val.size(); i++) begin
      check("rr_order", 32'(onset_val[i]), 32'(rr_exp[i]));
      if (i > 0) check("rr_spacing", 32'(onset_cyc[i] - onset_cyc[i-1]), 32'(H + 2));
    end
    drain();

    // single request, word 2'b10 on requester 2
    bus.reqIn  = 4'b0100;
    bus.dataIn = {2'($urandom), 2'b10, 4'($urandom)};
    step();
    check("single_grant", 32'(bus.grantOut), 32'h4);
    check("single_bits",  32'({bus.bitIn1, bus.bitIn2}), 32'h2);
    bus.reqIn = '0;
    for (int i = 0; i < H + 1; i++) step();
    check("single_busy_low", 32'(bus.busy), 32'd0);

    // request dropped and data flipped during HOLD are ignored
    bus.reqIn  = 4'b0001;
    bus.dataIn = 8'($urandom);
    step();
    bus.reqIn  = '0;
    bus.dataIn = ~bus.dataIn;
    for (int i = 0; i < H + 1; i++) step();

    // reset on the second HOLD cycle, then pointer must be back at 0
    bus.reqIn  = 4'b0010;
    bus.dataIn = 8'hFF;
    step();
    step();
    reset = 1'b1;
    step();
    reset     = 1'b0;
    bus.reqIn = 4'b1111;
    step();
    check("post_reset_grant", 32'(bus.grantOut), 32'h1);
    drain();

    // requesters 1 and 3 held; fixed priority never serves requester 3
    grant_or   = '0;
    bus.reqIn  = 4'b1010;
    bus.dataIn = 8'($urandom);
    for (int i = 0; i < 4 * (H + 2); i++) step();
    check("prio_grant_set", 32'(grant_or), 32'(fixed_exp));
    drain();

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      bus.reqIn  = 4'($urandom);
      bus.dataIn = 8'($urandom);
      reset      = ($urandom_range(0, 39) == 0);
      step();
    end
    reset = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
